// File: rtl/tdm_pkg.sv
// Shared constants and types for the 4-slot TDM receive path.
// Optional build macro: TDM_SYNC_CHECK_EN (missing slot-0 marker drops lock).
package tdm_pkg;

    localparam int NUM_SLOTS = 4;
    localparam int SLOT_W    = 2;

    typedef enum logic {
        HUNT = 1'b0,
        LOCK = 1'b1
    } state_e;

    localparam logic [SLOT_W-1:0] SLOT0 = 2'd0;
    localparam logic [SLOT_W-1:0] SLOT1 = 2'd1;
    localparam logic [SLOT_W-1:0] SLOT2 = 2'd2;
    localparam logic [SLOT_W-1:0] SLOT3 = 2'd3;

endpackage

// File: rtl/tdm_demux4_if.sv
// Serial-link input and parallel-channel output bundle of the TDM demux.
// The link side (master) drives DIN/EN/SYNC; the demux (slave) drives the rest.
interface tdm_demux4_if #(
    parameter int W = 1
);
    import tdm_pkg::*;

    logic [W-1:0]      DIN;
    logic              EN;
    logic              SYNC;
    logic [W-1:0]      Q0;
    logic [W-1:0]      Q1;
    logic [W-1:0]      Q2;
    logic [W-1:0]      Q3;
    logic              FRAME_VALID;
    logic              LOCKED;
    logic [SLOT_W-1:0] SLOT;
    logic              SYNC_ERR;

    modport master (
        output DIN, EN, SYNC,
        input  Q0, Q1, Q2, Q3, FRAME_VALID, LOCKED, SLOT, SYNC_ERR
    );

    modport slave (
        input  DIN, EN, SYNC,
        output Q0, Q1, Q2, Q3, FRAME_VALID, LOCKED, SLOT, SYNC_ERR
    );

endinterface

// File: rtl/tdm_slot_ctr.sv
// Slot position counter: load-to-1 on acquire/realign, load-to-0 on lock loss,
// otherwise increments (mod 4) on each accepted sample.
module tdm_slot_ctr
    import tdm_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              ld1,
    input  logic              ld0,
    input  logic              inc,
    output logic [SLOT_W-1:0] slot
);

    logic [SLOT_W-1:0] slot_q;

    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            slot_q <= SLOT0;
        end else if (ld1) begin
            slot_q <= SLOT1;
        end else if (ld0) begin
            slot_q <= SLOT0;
        end else if (inc) begin
            slot_q <= slot_q + SLOT_W'(1);
        end
    end

    assign slot = slot_q;

endmodule

// File: rtl/tdm_demux4.sv
// 4-slot TDM demultiplexer: acquires alignment from SYNC, shadows slots 0..2
// and publishes all four channels on slot 3. Macro: TDM_SYNC_CHECK_EN.
module tdm_demux4
    import tdm_pkg::*;
#(
    parameter int W = 1
) (
    input  logic          CLK,
    input  logic          RST,
    tdm_demux4_if.slave   bus
);

    state_e            state_q, state_d;
    logic [SLOT_W-1:0] slot;
    logic              ctr_ld1, ctr_ld0, ctr_inc;
    logic              shadow_we, commit, err;
    logic [SLOT_W-1:0] wr_idx;

    logic [W-1:0] shadow0_q, shadow1_q, shadow2_q;
    logic [W-1:0] q0_q, q1_q, q2_q, q3_q;
    logic         frame_valid_q, sync_err_q;

    tdm_slot_ctr u_slot_ctr (
        .clk  (CLK),
        .rst  (RST),
        .ld1  (ctr_ld1),
        .ld0  (ctr_ld0),
        .inc  (ctr_inc),
        .slot (slot)
    );

    always_ff @(posedge CLK) begin
        if (RST) state_q <= HUNT;
        else     state_q <= state_d;
    end

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d   = state_q;
        ctr_ld1   = 1'b0;
        ctr_ld0   = 1'b0;
        ctr_inc   = 1'b0;
        shadow_we = 1'b0;
        commit    = 1'b0;
        err       = 1'b0;
        wr_idx    = slot;

        unique case (state_q)
            HUNT: begin
                if (bus.EN && bus.SYNC) begin
                    shadow_we = 1'b1;
                    wr_idx    = SLOT0;
                    ctr_ld1   = 1'b1;
                    state_d   = LOCK;
                end
            end
            LOCK: begin
                if (bus.EN) begin
                    if (bus.SYNC && slot != SLOT0) begin
                        // Early marker: restart the frame on this sample.
                        err       = 1'b1;
                        shadow_we = 1'b1;
                        wr_idx    = SLOT0;
                        ctr_ld1   = 1'b1;
`ifdef TDM_SYNC_CHECK_EN
                    end else if (!bus.SYNC && slot == SLOT0) begin
                        err     = 1'b1;
                        ctr_ld0 = 1'b1;
                        state_d = HUNT;
`endif
                    end else if (slot == SLOT3) begin
                        commit  = 1'b1;
                        ctr_inc = 1'b1;
                    end else begin
                        shadow_we = 1'b1;
                        ctr_inc   = 1'b1;
                    end
                end
            end
            default: state_d = HUNT;
        endcase
    end

    // NOTE: shadow regs are reset along with the outputs so a reset never exposes stale channel data.
    always_ff @(posedge CLK) begin
        if (RST) begin
            shadow0_q <= '0;
            shadow1_q <= '0;
            shadow2_q <= '0;
        end else if (shadow_we) begin
            unique case (wr_idx)
                SLOT0:   shadow0_q <= bus.DIN;
                SLOT1:   shadow1_q <= bus.DIN;
                default: shadow2_q <= bus.DIN;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            q0_q          <= '0;
            q1_q          <= '0;
            q2_q          <= '0;
            q3_q          <= '0;
            frame_valid_q <= 1'b0;
            sync_err_q    <= 1'b0;
        end else begin
            frame_valid_q <= commit;
            sync_err_q    <= err;
            if (commit) begin
                q0_q <= shadow0_q;
                q1_q <= shadow1_q;
                q2_q <= shadow2_q;
                q3_q <= bus.DIN;
            end
        end
    end

    assign bus.Q0          = q0_q;
    assign bus.Q1          = q1_q;
    assign bus.Q2          = q2_q;
    assign bus.Q3          = q3_q;
    assign bus.FRAME_VALID = frame_valid_q;
    assign bus.SYNC_ERR    = sync_err_q;
    assign bus.LOCKED      = (state_q == LOCK);
    assign bus.SLOT        = slot;

endmodule

// File: tb/tb_tdm_demux4.sv
// Directed bench for tdm_demux4 (W=1); expectations follow the TDM_SYNC_CHECK_EN build setting.
module tb_tdm_demux4;
    import tdm_pkg::*;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    int   n_total = 0;
    int   n_pass  = 0;

    tdm_demux4_if #(.W(1)) bus ();

    tdm_demux4 #(.W(1)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus.slave)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Channels read as Q0,Q1,Q2,Q3 from MSB to LSB.
    function automatic logic [7:0] qv();
        return {4'b0, bus.Q0, bus.Q1, bus.Q2, bus.Q3};
    endfunction

    task automatic step(input logic en, input logic sync, input logic din);
        bus.EN   = en;
        bus.SYNC = sync;
        bus.DIN  = din;
        @(posedge CLK);
        #1;
    endtask

    task automatic expect_state(input string tag, input logic [7:0] q, input logic fv,
                                input logic lk, input logic [1:0] sl, input logic er);
        check({tag, ".q"},    qv(),                 q);
        check({tag, ".fv"},   {7'b0, bus.FRAME_VALID}, {7'b0, fv});
        check({tag, ".lock"}, {7'b0, bus.LOCKED},   {7'b0, lk});
        check({tag, ".slot"}, {6'b0, bus.SLOT},     {6'b0, sl});
        check({tag, ".err"},  {7'b0, bus.SYNC_ERR}, {7'b0, er});
    endtask

    initial begin
        bus.EN = 1'b0; bus.SYNC = 1'b0; bus.DIN = 1'b0;

        // Reset, then acquire frame 1,0,1,1
        RST = 1'b1;
        step(0, 0, 0);
        step(0, 0, 0);
        expect_state("reset", 8'h0, 0, 0, 2'd0, 0);
        RST = 1'b0;
        step(1, 1, 1); expect_state("acq0", 8'h0, 0, 1, 2'd1, 0);
        step(1, 0, 0); expect_state("acq1", 8'h0, 0, 1, 2'd2, 0);
        step(1, 0, 1); expect_state("acq2", 8'h0, 0, 1, 2'd3, 0);
        step(1, 0, 1); expect_state("acq3", 8'hB, 1, 1, 2'd0, 0);
        step(0, 0, 0); expect_state("acq_idle", 8'hB, 0, 1, 2'd0, 0);

        // Gapped frame 1,1,0,1 with 3 idle cycles between samples
        step(1, 1, 1); expect_state("gap0", 8'hB, 0, 1, 2'd1, 0);
        repeat (3) step(0, 1, 0);
        expect_state("gap0_hold", 8'hB, 0, 1, 2'd1, 0);
        step(1, 0, 1); expect_state("gap1", 8'hB, 0, 1, 2'd2, 0);
        repeat (3) step(0, 0, 1);
        step(1, 0, 0); expect_state("gap2", 8'hB, 0, 1, 2'd3, 0);
        repeat (3) step(0, 0, 0);
        expect_state("gap2_hold", 8'hB, 0, 1, 2'd3, 0);
        step(1, 0, 1); expect_state("gap3", 8'hD, 1, 1, 2'd0, 0);
        step(0, 0, 0); expect_state("gap_idle", 8'hD, 0, 1, 2'd0, 0);

        // Realign: SYNC arrives at SLOT=2 with DIN=0, then 1,1,0
        step(1, 1, 0); expect_state("ra0", 8'hD, 0, 1, 2'd1, 0);
        step(1, 0, 1); expect_state("ra1", 8'hD, 0, 1, 2'd2, 0);
        step(1, 1, 0); expect_state("ra_err", 8'hD, 0, 1, 2'd1, 1);
        step(1, 0, 1); expect_state("ra_s1", 8'hD, 0, 1, 2'd2, 0);
        step(1, 0, 1); expect_state("ra_s2", 8'hD, 0, 1, 2'd3, 0);
        step(1, 0, 0); expect_state("ra_s3", 8'h6, 1, 1, 2'd0, 0);

        // Slot-0 sample without SYNC, then 0,1,1
`ifdef TDM_SYNC_CHECK_EN
        step(1, 0, 1); expect_state("miss", 8'h6, 0, 0, 2'd0, 1);
        step(1, 0, 0); expect_state("miss_h1", 8'h6, 0, 0, 2'd0, 0);
        step(1, 0, 1); expect_state("miss_h2", 8'h6, 0, 0, 2'd0, 0);
        step(1, 0, 1); expect_state("miss_h3", 8'h6, 0, 0, 2'd0, 0);
`else
        step(1, 0, 1); expect_state("free0", 8'h6, 0, 1, 2'd1, 0);
        step(1, 0, 0); expect_state("free1", 8'h6, 0, 1, 2'd2, 0);
        step(1, 0, 1); expect_state("free2", 8'h6, 0, 1, 2'd3, 0);
        step(1, 0, 1); expect_state("free3", 8'hB, 1, 1, 2'd0, 0);
`endif

        // Reacquire, then reset at SLOT=2
        step(1, 1, 1);
        step(1, 0, 1);
        check("pre_rst.slot", {6'b0, bus.SLOT}, 8'd2);
        RST = 1'b1;
        step(1, 0, 1); expect_state("midrst", 8'h0, 0, 0, 2'd0, 0);
        RST = 1'b0;

        // HUNT filter: samples without SYNC, and SYNC without EN, are ignored
        for (int i = 0; i < 6; i++) begin
            step(1, 0, 1);
            expect_state($sformatf("hunt%0d", i), 8'h0, 0, 0, 2'd0, 0);
        end
        step(0, 1, 1); expect_state("hunt_noen", 8'h0, 0, 0, 2'd0, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
